// File: rtl/pe_array_sequencer_if.sv
// Decoder-to-sequencer instruction issue bus: valid/ready handshake plus the
// decoded vector instruction fields.
interface pe_array_sequencer_if #(
  parameter int MAX_VL = 64
);
  logic                         req_valid;
  logic                         req_ready;
  logic [3:0]                   req_arith_op;
  logic [1:0]                   req_out_mode;
  logic [1:0]                   req_sat_mode;
  logic [1:0]                   req_operand;
  logic [1:0]                   req_sew;
  logic [$clog2(MAX_VL+1)-1:0]  req_vl;
  logic [4:0]                   req_vd;
  logic [4:0]                   req_vs1;
  logic [4:0]                   req_vs2;

  modport master (
    output req_valid, req_arith_op, req_out_mode, req_sat_mode, req_operand,
           req_sew, req_vl, req_vd, req_vs1, req_vs2,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_arith_op, req_out_mode, req_sat_mode, req_operand,
           req_sew, req_vl, req_vd, req_vs1, req_vs2,
    output req_ready
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Sequences one vector instruction across the PE array in word-groups, delays
// writeback control by PE_LAT and generates tail / reduction byte enables.
module pe_array_sequencer #(
  parameter int NUM_PE = 4,
  parameter int PE_LAT = 2,
  parameter int MAX_VL = 64,
  parameter int GRP_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_array_sequencer_if.slave     req,
  input  logic                    stall,
  output logic                    pe_valid,
  output logic [3:0]              pe_arith_op,
  output logic [1:0]              pe_out_mode,
  output logic [1:0]              pe_sat_mode,
  output logic [1:0]              pe_operand,
  output logic [5+GRP_W-1:0]      rd_vs1_addr,
  output logic [5+GRP_W-1:0]      rd_vs2_addr,
  output logic                    wb_valid,
  output logic [5+GRP_W-1:0]      wb_addr,
  output logic [NUM_PE*4-1:0]     wb_be,
  output logic                    done,
  output logic                    err
);
  localparam int BPG = NUM_PE * 4;
  localparam int BW  = 16;
  localparam logic [1:0] OP_RIPPLE = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       sew_q;
  logic [4:0]       vd_q, vs1_q, vs2_q;
  logic [BW-1:0]    vl_bytes;
  logic [GRP_W-1:0] grp;
  logic             err_q;

  logic [PE_LAT-1:0] dl_valid;
  logic [PE_LAT-1:0] dl_last;
  logic [GRP_W-1:0]  dl_grp [PE_LAT];
  logic [BPG-1:0]    dl_be  [PE_LAT];

  logic             issue_fire, is_last, pending, ripple, head_v;
  logic [BW-1:0]    grp_end, grp_base, rem;
  logic [BPG-1:0]   be_issue, red_be;

  always_comb begin
    issue_fire = (state == S_ISSUE) && !stall;
    ripple     = (pe_operand == OP_RIPPLE);
    // Last group is the one whose byte window reaches the end of vl, so no divide is needed.
    grp_end    = BW'((32'(grp) + 32'd1) * 32'(BPG));
    grp_base   = BW'(32'(grp) * 32'(BPG));
    is_last    = (grp_end >= vl_bytes);
    rem        = vl_bytes - grp_base;
    be_issue   = '0;
    red_be     = '0;
    for (int unsigned b = 0; b < BPG; b++) begin
      be_issue[b] = !is_last || (BW'(b) < rem);
      red_be[b]   = (b < (32'd1 << sew_q));
    end
    // Stages that will still hold a group after the next shift.
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < PE_LAT; i++) pending = pending | dl_valid[i];

    head_v      = dl_valid[PE_LAT-1] && !stall;
    wb_valid    = head_v && (!ripple || dl_last[PE_LAT-1]);
    wb_addr     = '0;
    wb_be       = '0;
    if (wb_valid) begin
      wb_addr = {vd_q, (ripple ? GRP_W'(0) : dl_grp[PE_LAT-1])};
      wb_be   = ripple ? red_be : dl_be[PE_LAT-1];
    end
    pe_valid    = issue_fire;
    rd_vs1_addr = {vs1_q, grp};
    rd_vs2_addr = {vs2_q, grp};
    req.req_ready = (state == S_IDLE);
    done        = (state == S_DONE) && !stall;
    err         = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pe_arith_op <= '0;
      pe_out_mode <= '0;
      pe_sat_mode <= '0;
      pe_operand  <= '0;
      sew_q       <= '0;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vl_bytes    <= '0;
      grp         <= '0;
      err_q       <= 1'b0;
      dl_valid    <= '0;
      dl_last     <= '0;
      for (int unsigned i = 0; i < PE_LAT; i++) begin
        dl_grp[i] <= '0;
        dl_be[i]  <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req.req_valid) begin
            pe_arith_op <= req.req_arith_op;
            pe_out_mode <= req.req_out_mode;
            pe_sat_mode <= req.req_sat_mode;
            pe_operand  <= req.req_operand;
            sew_q       <= req.req_sew;
            vd_q        <= req.req_vd;
            vs1_q       <= req.req_vs1;
            vs2_q       <= req.req_vs2;
            vl_bytes    <= BW'(req.req_vl) << req.req_sew;
            grp         <= '0;
            if (req.req_sew == 2'd3)    err_q <= 1'b1;
            else if (req.req_vl == '0)  state <= S_DONE;
            else                        state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            if (is_last) state <= S_DRAIN;
            else         grp   <= grp + GRP_W'(1);
          end
        end
        S_DRAIN: if (!stall && !pending) state <= S_DONE;
        S_DONE:  if (!stall) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (!stall) begin
        dl_valid[0] <= issue_fire;
        dl_last[0]  <= is_last;
        dl_grp[0]   <= grp;
        dl_be[0]    <= be_issue;
        for (int unsigned i = 1; i < PE_LAT; i++) begin
          dl_valid[i] <= dl_valid[i-1];
          dl_last[i]  <= dl_last[i-1];
          dl_grp[i]   <= dl_grp[i-1];
          dl_be[i]    <= dl_be[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed, table-driven bench for pe_array_sequencer (NUM_PE=4, PE_LAT=2).
module tb_pe_array_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic        pe_valid, wb_valid, done, err;
  logic [3:0]  pe_arith_op;
  logic [1:0]  pe_out_mode, pe_sat_mode, pe_operand;
  logic [8:0]  rd_vs1_addr, rd_vs2_addr, wb_addr;
  logic [15:0] wb_be;

  pe_array_sequencer_if #(.MAX_VL(64)) rif ();

  pe_array_sequencer #(.NUM_PE(4), .PE_LAT(2), .MAX_VL(64), .GRP_W(4)) dut (
    .clk(clk), .rst(rst), .req(rif.slave), .stall(stall),
    .pe_valid(pe_valid), .pe_arith_op(pe_arith_op), .pe_out_mode(pe_out_mode),
    .pe_sat_mode(pe_sat_mode), .pe_operand(pe_operand),
    .rd_vs1_addr(rd_vs1_addr), .rd_vs2_addr(rd_vs2_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_be(wb_be),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-transaction capture (cycle k = k cycles after the acceptance cycle)
  int          n_pe, n_wb, n_done, n_err, done_at, err_at;
  int          pe_cyc [8];
  logic [8:0]  pe_a1 [8];
  logic [8:0]  pe_a2 [8];
  int          wb_cyc [8];
  logic [8:0]  wb_ad [8];
  logic [15:0] wb_bv [8];

  typedef struct {
    logic [1:0]  sew;
    logic [6:0]  vl;
    logic [1:0]  opnd;
    logic [4:0]  vd;
    logic [3:0]  arith;
    int          n_pe;
    int          n_wb;
    int          first_wb;
    logic [15:0] be_last;
    int          done_at;
    int          err_at;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] sew, input logic [6:0] vl, input logic [1:0] opnd,
                         input logic [4:0] vd, input logic [3:0] arith,
                         input int st_from, input int st_len);
    n_pe = 0; n_wb = 0; n_done = 0; n_err = 0; done_at = -1; err_at = -1;
    @(negedge clk);
    rif.req_valid    = 1'b1;
    rif.req_sew      = sew;
    rif.req_vl       = vl;
    rif.req_operand  = opnd;
    rif.req_vd       = vd;
    rif.req_vs1      = vd + 5'd1;
    rif.req_vs2      = vd + 5'd2;
    rif.req_arith_op = arith;
    rif.req_out_mode = 2'd1;
    rif.req_sat_mode = 2'd2;
    @(posedge clk);
    #1;
    rif.req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      stall = (k >= st_from) && (k < st_from + st_len);
      #1;
      if (pe_valid) begin
        if (n_pe < 8) begin pe_cyc[n_pe] = k; pe_a1[n_pe] = rd_vs1_addr; pe_a2[n_pe] = rd_vs2_addr; end
        n_pe++;
      end
      if (wb_valid) begin
        if (n_wb < 8) begin wb_cyc[n_wb] = k; wb_ad[n_wb] = wb_addr; wb_bv[n_wb] = wb_be; end
        n_wb++;
      end
      if (done) begin if (done_at < 0) done_at = k; n_done++; end
      if (err)  begin if (err_at < 0) err_at = k;  n_err++;  end
    end
    stall = 1'b0;
  endtask

  initial begin
    //           sew   vl     opnd  vd     op     npe nwb fwb be_last   done err
    vecs[0] = '{2'd0, 7'd10, 2'd0, 5'd5,  4'h1,  1,  1,  3,  16'h03FF, 4,   -1};
    vecs[1] = '{2'd1, 7'd20, 2'd0, 5'd3,  4'h2,  3,  3,  3,  16'h00FF, 6,   -1};
    vecs[2] = '{2'd0, 7'd0,  2'd0, 5'd9,  4'h3,  0,  0,  0,  16'h0000, 1,   -1};
    vecs[3] = '{2'd2, 7'd8,  2'd3, 5'd7,  4'h4,  2,  1,  4,  16'h000F, 5,   -1};
    vecs[4] = '{2'd3, 7'd5,  2'd0, 5'd2,  4'h5,  0,  0,  0,  16'h0000, -1,  1};
    vecs[5] = '{2'd2, 7'd16, 2'd0, 5'd1,  4'h6,  4,  4,  3,  16'hFFFF, 7,   -1};
    vecs[6] = '{2'd2, 7'd5,  2'd0, 5'd4,  4'h7,  2,  2,  3,  16'h000F, 5,   -1};
    vecs[7] = '{2'd1, 7'd9,  2'd3, 5'd31, 4'h8,  2,  1,  4,  16'h0003, 5,   -1};

    rif.req_valid = 1'b0; rif.req_sew = '0; rif.req_vl = '0; rif.req_operand = '0;
    rif.req_vd = '0; rif.req_vs1 = '0; rif.req_vs2 = '0; rif.req_arith_op = '0;
    rif.req_out_mode = '0; rif.req_sat_mode = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rif.req_ready), 32'd1);
    chk("rst_pe_valid", 32'(pe_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_wb_be", 32'(wb_be), 32'd0);
    chk("rst_addrs", 32'({rd_vs1_addr, rd_vs2_addr, wb_addr}), 32'd0);
    chk("rst_ctl", 32'({pe_arith_op, pe_out_mode, pe_sat_mode, pe_operand}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      vec_t t;
      t = vecs[v];
      run_txn(t.sew, t.vl, t.opnd, t.vd, t.arith, 99, 0);
      chk($sformatf("v%0d_n_pe", v), 32'(n_pe), 32'(t.n_pe));
      for (int i = 0; i < n_pe && i < t.n_pe && i < 8; i++) begin
        chk($sformatf("v%0d_pe_cyc%0d", v, i), 32'(pe_cyc[i]), 32'(1 + i));
        chk($sformatf("v%0d_rd_vs1_%0d", v, i), 32'(pe_a1[i]), 32'({t.vd + 5'd1, 4'(i)}));
        chk($sformatf("v%0d_rd_vs2_%0d", v, i), 32'(pe_a2[i]), 32'({t.vd + 5'd2, 4'(i)}));
      end
      chk($sformatf("v%0d_n_wb", v), 32'(n_wb), 32'(t.n_wb));
      for (int i = 0; i < n_wb && i < t.n_wb && i < 8; i++) begin
        logic [3:0]  eg;
        logic [15:0] eb;
        eg = (t.opnd == 2'd3) ? 4'd0 : 4'(i);
        eb = (i == t.n_wb - 1) ? t.be_last : 16'hFFFF;
        chk($sformatf("v%0d_wb_cyc%0d", v, i), 32'(wb_cyc[i]), 32'(t.first_wb + i));
        chk($sformatf("v%0d_wb_addr%0d", v, i), 32'(wb_ad[i]), 32'({t.vd, eg}));
        chk($sformatf("v%0d_wb_be%0d", v, i), 32'(wb_bv[i]), 32'(eb));
      end
      chk($sformatf("v%0d_done_at", v), 32'(done_at), 32'(t.done_at));
      chk($sformatf("v%0d_n_done", v), 32'(n_done), (t.done_at < 0) ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_err_at", v), 32'(err_at), 32'(t.err_at));
      chk($sformatf("v%0d_n_err", v), 32'(n_err), (t.err_at < 0) ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_ctl", v), 32'({pe_arith_op, pe_out_mode, pe_sat_mode, pe_operand}),
          32'({t.arith, 2'd1, 2'd2, t.opnd}));
      chk($sformatf("v%0d_ready", v), 32'(rif.req_ready), 32'd1);
    end

    // Stall for two cycles starting at T+2: everything slides by 2, no groups lost.
    begin
      int          epc [3];
      int          ewc [3];
      logic [15:0] ebe [3];
      epc = '{1, 4, 5};
      ewc = '{5, 6, 7};
      ebe = '{16'hFFFF, 16'hFFFF, 16'h00FF};
      run_txn(2'd1, 7'd20, 2'd0, 5'd3, 4'h9, 2, 2);
      chk("stall_n_pe", 32'(n_pe), 32'd3);
      chk("stall_n_wb", 32'(n_wb), 32'd3);
      for (int i = 0; i < 3; i++) begin
        if (i < n_pe) begin
          chk($sformatf("stall_pe_cyc%0d", i), 32'(pe_cyc[i]), 32'(epc[i]));
          chk($sformatf("stall_rd_vs1_%0d", i), 32'(pe_a1[i]), 32'({5'd4, 4'(i)}));
        end
        if (i < n_wb) begin
          chk($sformatf("stall_wb_cyc%0d", i), 32'(wb_cyc[i]), 32'(ewc[i]));
          chk($sformatf("stall_wb_addr%0d", i), 32'(wb_ad[i]), 32'({5'd3, 4'(i)}));
          chk($sformatf("stall_wb_be%0d", i), 32'(wb_bv[i]), 32'(ebe[i]));
        end
      end
      chk("stall_done_at", 32'(done_at), 32'd8);
      chk("stall_n_done", 32'(n_done), 32'd1);
    end

    // Reset asserted mid-ISSUE aborts immediately.
    begin
      int late_pe, late_wb, late_done;
      late_pe = 0; late_wb = 0; late_done = 0;
      @(negedge clk);
      rif.req_valid = 1'b1; rif.req_sew = 2'd2; rif.req_vl = 7'd16; rif.req_operand = 2'd0;
      rif.req_vd = 5'd6; rif.req_vs1 = 5'd7; rif.req_vs2 = 5'd8; rif.req_arith_op = 4'hB;
      @(posedge clk);
      #1;
      rif.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_pe_valid_before", 32'(pe_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_pe_valid", 32'(pe_valid), 32'd0);
      chk("mid_rst_wb", 32'({wb_valid, wb_be, wb_addr}), 32'd0);
      chk("mid_rst_done_err", 32'({done, err}), 32'd0);
      chk("mid_rst_addr", 32'(rd_vs1_addr), 32'd0);
      chk("mid_rst_ctl", 32'(pe_arith_op), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #2;
        if (pe_valid) late_pe++;
        if (wb_valid) late_wb++;
        if (done)     late_done++;
      end
      chk("mid_after_pe", 32'(late_pe), 32'd0);
      chk("mid_after_wb", 32'(late_wb), 32'd0);
      chk("mid_after_done", 32'(late_done), 32'd0);
      chk("mid_after_ready", 32'(rif.req_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pe_array_sequencer.md
Name: pe_array_sequencer

Overview:
- Controller that sequences one decoded vector arithmetic instruction across the NUM_PE-lane PE array.
- Splits vl elements into word-groups and drives PE control (arith op, output mode, saturation, operand select) once per group.
- Generates vector-register read addresses, delays writeback control to match PE latency, and computes tail byte-enables.
- Handles ripple-mode reductions (single final writeback); sits between the decoder issue handshake and the PE array / vreg writeback port.

Parameters:
- NUM_PE, 4, number of 32-bit PE lanes; bytes per group = NUM_PE*4.
- PE_LAT, 2, cycles from pe_valid to result available (>=1).
- MAX_VL, 64, maximum vl accepted.
- GRP_W, 4, group-index width (2^GRP_W >= MAX_VL/1 element-per-lane groups).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  instruction offered
- req_ready  out  1  sequencer idle, can accept
- req_arith_op  in  4  pe_arith_op_t
- req_out_mode  in  2  pe_output_mode_t
- req_sat_mode  in  2  pe_saturation_mode_t
- req_operand  in  2  pe_operand_t
- req_sew  in  2  0=8b, 1=16b, 2=32b, 3=illegal
- req_vl  in  $clog2(MAX_VL+1)  element count
- req_vd, req_vs1, req_vs2  in  5 each  register indices
- stall  in  1  freeze issue and delay line
- pe_valid  out  1  PE inputs valid this cycle
- pe_arith_op / pe_out_mode / pe_sat_mode / pe_operand  out  4/2/2/2  latched control
- rd_vs1_addr, rd_vs2_addr  out  5+GRP_W  {reg, group}
- wb_valid  out  1  write result to vd
- wb_addr  out  5+GRP_W  {vd, group}
- wb_be  out  NUM_PE*4  byte enables
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on illegal sew

Behaviour:
- Reset: state IDLE; req_ready=1; pe_valid, wb_valid, done, err=0; wb_be=0; all addresses and control=0; delay line cleared. Reset mid-operation aborts immediately with no further pulses.
- EPG (elements per group) = (NUM_PE*4)>>sew. G = ceil(vl/EPG).
- IDLE: req_ready=1. Accept on req_valid&&req_ready; latch all req_* fields.
  - sew==3 -> err=1 next cycle, return to IDLE, no issue, no done.
  - vl==0 -> DONE next cycle, no issue.
  - Otherwise -> ISSUE, grp=0.
- ISSUE: req_ready=0.
  - Each non-stalled cycle: pe_valid=1, rd addresses={vs,grp}, grp++.
  - After issuing grp==G-1 -> DRAIN.
  - First pe_valid occurs the cycle after acceptance.
- Delay line: PE_LAT-deep shift of {valid, grp, last, be}. wb_valid asserts exactly PE_LAT non-stalled cycles after the matching pe_valid.
- wb_be:
  - Non-last groups: all ones.
  - Last group: low ((vl-(G-1)*EPG)<<sew) bytes set, rest 0.
- Reduction (operand==RIPPLE): all groups issued as normal; wb_valid only for the last group, wb_addr={vd,0}, wb_be = low (1<<sew) bytes.
- DRAIN: wait until delay line empty -> DONE.
- DONE: done=1 for one cycle, the cycle after the last wb_valid (or after acceptance for vl==0) -> IDLE.
- Stall: while stall=1, pe_valid=0, wb_valid=0, grp and delay line hold, state holds. Outputs resume unchanged when stall drops.
- stall during IDLE has no effect on acceptance.
- Control outputs hold latched values until the next acceptance.

Test Plan:
- NUM_PE=4, sew=0, vl=10, accept at T -> pe_valid only at T+1 (grp 0); wb_valid at T+3 with wb_be=0x03FF; done at T+4.
- sew=1, vl=20, vd=3 -> EPG=8, G=3; pe_valid T+1..T+3 with rd grp 0,1,2; wb_valid T+3..T+5 with addr {3,0..2}; be 0xFFFF,0xFFFF,0x00FF; done T+6.
- vl=0 -> no pe_valid or wb_valid; done at T+1; req_ready high again at T+2.
- operand=RIPPLE, sew=2, vl=8 -> two pe_valid; exactly one wb_valid at T+4, addr {vd,0}, be=0x000F; done T+5.
- sew=1, vl=20 with stall high for 2 cycles at T+2 -> issue and writeback slide by 2; done at T+8; no duplicated or dropped groups.
- sew=3 -> err pulse at T+1, no pe_valid, no done. Separately, rst asserted mid-ISSUE -> all outputs 0 immediately, req_ready=1 after release.
